// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_TRAP
    } mc_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Raw per-state controls from the main FSM, before reset gating.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       trap_entry;
    } mc_ctrl_t;

    function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects and enables out.
interface multicycle_controller_if #(parameter int XLEN_CNT = 32);
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic                funct7b5;
    logic                Zero;
    logic                mem_ready;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic                RegWrite;
    logic [1:0]          ImmSrc;
    logic [2:0]          ALUControl;
    logic                retire;
    logic [XLEN_CNT-1:0] instret;
    logic                trap;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, retire, instret, trap
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, retire, instret, trap
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction fields onto the 3-bit ALU operation.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALUOP_ADD: alu_control = 3'b000;
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type uses bit 30 to select sub; for addi it is an immediate bit.
                    3'b000:  alu_control = (op_b5 & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main Moore sequencer: state register, next-state logic and per-state controls.
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output mc_ctrl_t   ctrl
);

    mc_state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
                ctrl.alu_op     = ALUOP_ADD;
                // Enables fire only on the completing cycle so a stalled fetch loads once.
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d         = S_TRAP;
                        ctrl.trap_entry = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
                state_d         = S_ALUWB;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller top: FSM, ALU decoder, ImmSrc decode, PC enable, retire counter and trap flag.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int XLEN_CNT = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multicycle_controller_if.master  bus
);

    mc_ctrl_t            ctrl;
    logic [XLEN_CNT-1:0] instret_q, instret_d;
    logic                trap_q, trap_d;
    logic                retire_g;

    mc_main_fsm u_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (bus.op),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    mc_alu_dec u_alu_dec (
        .alu_op      (ctrl.alu_op),
        .funct3      (bus.funct3),
        .op_b5       (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (bus.ALUControl)
    );

    // The FSM sits in FETCH during reset; gating keeps the enables dead until release.
    assign retire_g      = reset_n & ctrl.retire;
    assign bus.PCWrite   = reset_n & ((ctrl.branch & bus.Zero) | ctrl.pc_update);
    assign bus.IRWrite   = reset_n & ctrl.ir_write;
    assign bus.RegWrite  = reset_n & ctrl.reg_write;
    assign bus.MemWrite  = reset_n & ctrl.mem_write;
    assign bus.retire    = retire_g;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ResultSrc = ctrl.result_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ImmSrc    = imm_src_decode(bus.op);
    assign bus.instret   = instret_q;
    assign bus.trap      = trap_q;

    always_comb begin
        instret_d = instret_q;
        trap_d    = trap_q | ctrl.trap_entry;
        if (retire_g) instret_d = instret_q + XLEN_CNT'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances (32-bit and 4-bit instret) on shared stimulus.
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller_if #(.XLEN_CNT(32)) bus ();
    multicycle_controller_if #(.XLEN_CNT(4))  bus4 ();

    assign bus.op        = op;
    assign bus.funct3    = funct3;
    assign bus.funct7b5  = funct7b5;
    assign bus.Zero      = zero;
    assign bus.mem_ready = mem_ready;
    assign bus4.op        = op;
    assign bus4.funct3    = funct3;
    assign bus4.funct7b5  = funct7b5;
    assign bus4.Zero      = zero;
    assign bus4.mem_ready = mem_ready;

    multicycle_controller #(.XLEN_CNT(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    multicycle_controller #(.XLEN_CNT(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] enables();
        return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.retire};
    endfunction

    initial begin
        int ir_cnt, ir_cyc, ret_cyc, ret_cnt, mw_cnt, mw_first, adr_bad, en_bad, trap_bad;
        logic [1:0] res_at_ret;

        reset_n = 1'b0; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("rst_enables", 32'(enables()), 0);
        check("rst_instret", bus.instret, 0);
        check("rst_trap", 32'(bus.trap), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;

        // add: FETCH, DECODE, EXECUTER, ALUWB
        check("add_fetch_irwrite", 32'(bus.IRWrite), 1);
        check("add_fetch_pcwrite", 32'(bus.PCWrite), 1);
        check("add_fetch_srcb", 32'(bus.ALUSrcB), 2);
        check("add_fetch_result", 32'(bus.ResultSrc), 2);
        tick(); #1;
        check("add_decode_srca", 32'(bus.ALUSrcA), 1);
        check("add_decode_srcb", 32'(bus.ALUSrcB), 1);
        check("add_decode_irwrite", 32'(bus.IRWrite), 0);
        tick(); #1;
        check("add_exec_srca", 32'(bus.ALUSrcA), 2);
        check("add_exec_srcb", 32'(bus.ALUSrcB), 0);
        check("add_exec_aluctl", 32'(bus.ALUControl), 0);
        tick(); #1;
        check("add_wb_regwrite", 32'(bus.RegWrite), 1);
        check("add_wb_retire", 32'(bus.retire), 1);
        check("add_wb_result", 32'(bus.ResultSrc), 0);
        tick(); #1;
        check("add_instret", bus.instret, 1);

        // lw with mem_ready low for the first two fetch cycles
        op = OP_LW;
        #0 check("lw_immsrc", 32'(bus.ImmSrc), 0);
        ir_cnt = 0; ir_cyc = 0; ret_cyc = 0; res_at_ret = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            mem_ready = (c >= 3);
            #1;
            if (bus.IRWrite) begin ir_cnt++; ir_cyc = c; end
            if (bus.retire) begin ret_cyc = c; res_at_ret = bus.ResultSrc; end
            tick();
        end
        #1;
        check("lw_ir_pulses", ir_cnt, 1);
        check("lw_ir_cycle", ir_cyc, 3);
        check("lw_retire_cycle", ret_cyc, 7);
        check("lw_memwb_result", 32'(res_at_ret), 1);
        check("lw_instret", bus.instret, 2);

        // sw with mem_ready low for three MEMWRITE cycles
        op = OP_SW;
        #0 check("sw_immsrc", 32'(bus.ImmSrc), 1);
        mw_cnt = 0; mw_first = 0; adr_bad = 0; ret_cnt = 0; ret_cyc = 0;
        for (int c = 1; c <= 7; c++) begin
            mem_ready = !(c >= 4 && c <= 6);
            #1;
            if (bus.MemWrite) begin
                mw_cnt++;
                if (mw_first == 0) mw_first = c;
                if (!bus.AdrSrc) adr_bad++;
            end
            if (bus.retire) begin ret_cnt++; ret_cyc = c; end
            tick();
        end
        #1;
        check("sw_memwrite_cycles", mw_cnt, 4);
        check("sw_memwrite_first", mw_first, 4);
        check("sw_adrsrc_bad", adr_bad, 0);
        check("sw_retire_count", ret_cnt, 1);
        check("sw_retire_cycle", ret_cyc, 7);
        check("sw_after_memwrite", 32'(bus.MemWrite), 0);
        check("sw_instret", bus.instret, 3);

        // beq taken then not taken
        op = OP_BEQ; zero = 1'b1; mem_ready = 1'b1;
        #0 check("beq_immsrc", 32'(bus.ImmSrc), 2);
        tick(); #1;
        check("beq_decode_pcwrite", 32'(bus.PCWrite), 0);
        tick(); #1;
        check("beq_taken_pcwrite", 32'(bus.PCWrite), 1);
        check("beq_taken_aluctl", 32'(bus.ALUControl), 1);
        check("beq_taken_retire", 32'(bus.retire), 1);
        tick(); zero = 1'b0;
        tick(); tick(); #1;
        check("beq_nt_pcwrite", 32'(bus.PCWrite), 0);
        check("beq_nt_aluctl", 32'(bus.ALUControl), 1);
        check("beq_nt_retire", 32'(bus.retire), 1);
        tick();

        // jal
        op = OP_JAL;
        #0 check("jal_immsrc", 32'(bus.ImmSrc), 3);
        tick(); tick(); #1;
        check("jal_pcwrite", 32'(bus.PCWrite), 1);
        check("jal_srca", 32'(bus.ALUSrcA), 1);
        check("jal_srcb", 32'(bus.ALUSrcB), 2);
        check("jal_regwrite", 32'(bus.RegWrite), 0);
        tick(); #1;
        check("jal_wb_retire", 32'(bus.retire), 1);
        check("jal_wb_regwrite", 32'(bus.RegWrite), 1);
        tick();

        // slti, sub, addi with bit 30 set
        op = OP_I; funct3 = 3'b010;
        tick(); tick(); #1;
        check("slti_aluctl", 32'(bus.ALUControl), 5);
        check("slti_srcb", 32'(bus.ALUSrcB), 1);
        tick(); tick();
        op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick(); #1;
        check("sub_aluctl", 32'(bus.ALUControl), 1);
        tick(); tick();
        op = OP_I;
        tick(); tick(); #1;
        check("addi_b30_aluctl", 32'(bus.ALUControl), 0);
        tick(); tick(); #1;
        check("mix_instret", bus.instret, 9);

        // illegal opcode -> TRAP, stuck with enables off
        op = 7'b1111111; funct7b5 = 1'b0;
        tick(); #1;
        check("ill_decode_trap", 32'(bus.trap), 0);
        tick();
        en_bad = 0; trap_bad = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = c[0];
            zero = 1'b1;
            op = (c >= 5) ? OP_R : 7'b1111111;
            #1;
            if (enables() != 5'b0) en_bad++;
            if (!bus.trap) trap_bad++;
            tick();
        end
        check("trap_enables_bad", en_bad, 0);
        check("trap_flag_bad", trap_bad, 0);

        // asynchronous reset clears trap and instret
        zero = 1'b0; mem_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        check("trap_rst_trap", 32'(bus.trap), 0);
        check("trap_rst_instret", bus.instret, 0);
        check("trap_rst_enables", 32'(enables()), 0);
        tick();
        reset_n = 1'b1; op = OP_LW;
        #1;
        check("abort_fetch_irwrite", 32'(bus.IRWrite), 1);
        tick(); tick(); #1;
        check("abort_memadr_srca", 32'(bus.ALUSrcA), 2);
        check("abort_memadr_srcb", 32'(bus.ALUSrcB), 1);
        reset_n = 1'b0;
        #1;
        check("abort_rst_enables", 32'(enables()), 0);
        tick();
        reset_n = 1'b1;
        #1;
        check("abort_refetch_irwrite", 32'(bus.IRWrite), 1);
        check("abort_instret", bus.instret, 0);

        // 16 R-type retirements: 4-bit counter wraps to 0
        op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            repeat (4) tick();
            if (i == 15) begin
                #1;
                check("wrap_cnt4_at15", 32'(bus4.instret), 15);
            end
        end
        #1;
        check("wrap_cnt4_at16", 32'(bus4.instret), 0);
        check("wrap_cnt32_at16", bus.instret, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
